window_addr_scheduler: RTL and testbench

//  Generates the read-address stream that feeds a KROWS-tall sliding window from a frame in dual-clock SRAM.
//  It replaces the bench-side C0..C4 scheduler in front of sobelFilter and generalises it in four ways:

---
 rtl/window_addr_scheduler_pkg.sv | 20 ++
 rtl/window_addr_scheduler_if.sv | 33 +++
 rtl/window_addr_scheduler_tag_delay_line.sv | 45 ++++
 rtl/window_addr_scheduler.sv | 176 +++++++++++++++++
 tb/tb_window_addr_scheduler.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/window_addr_scheduler_pkg.sv
// Shared types and helpers for the sliding-window read-address scheduler.
package window_addr_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    // Ceiling log2 with a floor of one bit, so single-valued fields stay legal.
    function automatic int unsigned sched_clog2(input int unsigned v);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < v) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/window_addr_scheduler_if.sv
// Control handshake, SRAM read request and returned-data tag bundle.
interface window_addr_scheduler_if #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned TAP_W  = 2,
    parameter int unsigned COL_W  = 8,
    parameter int unsigned ROW_W  = 8
);
    logic              start;
    logic              stall;
    logic              abort;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              busy;
    logic              done;
    logic              tag_valid;
    logic [TAP_W-1:0]  tag_tap;
    logic [COL_W-1:0]  tag_col;
    logic [ROW_W-1:0]  tag_row;
    logic              tag_eol;
    logic              tag_eof;

    modport master (
        output start, stall, abort,
        input  rd_en, rd_addr, busy, done,
        input  tag_valid, tag_tap, tag_col, tag_row, tag_eol, tag_eof
    );

    modport slave (
        input  start, stall, abort,
        output rd_en, rd_addr, busy, done,
        output tag_valid, tag_tap, tag_col, tag_row, tag_eol, tag_eof
    );
endinterface

// File: rtl/window_addr_scheduler_tag_delay_line.sv
// Fixed-depth delay line for read tags; valid bits can be flushed in one cycle.
module tag_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_pass;
            assign unused_pass = ^{clk, reset, clr_i};
            assign valid_o     = valid_i;
            assign data_o      = data_i;
        end else begin : g_pipe
            logic             valid_q [DEPTH];
            logic [WIDTH-1:0] data_q  [DEPTH];

            // Shift tags one stage per cycle; clr_i drops every valid bit at once.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        valid_q[i] <= 1'b0;
                        data_q[i]  <= '0;
                    end
                end else begin
                    valid_q[0] <= valid_i & ~clr_i;
                    data_q[0]  <= data_i;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        valid_q[i] <= valid_q[i-1] & ~clr_i;
                        data_q[i]  <= data_q[i-1];
                    end
                end
            end

            assign valid_o = valid_q[DEPTH-1];
            assign data_o  = data_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/window_addr_scheduler.sv
// Issues the column-major tap address stream for a KROWS-tall sliding window
// over an IMG_W x IMG_H frame and tags each read so it lines up with SRAM q.
module window_addr_scheduler
    import window_addr_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned IMG_W    = 256,
    parameter int unsigned IMG_H    = 256,
    parameter int unsigned KROWS    = 4,
    parameter int unsigned ROW_STEP = 1,
    parameter int unsigned RAM_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    window_addr_scheduler_if.slave bus
);
    localparam int unsigned TAP_W    = sched_clog2(KROWS);
    localparam int unsigned COL_W    = sched_clog2(IMG_W);
    localparam int unsigned ROW_W    = sched_clog2(IMG_H);
    localparam int unsigned DRN_W    = sched_clog2(RAM_LAT + 1);
    localparam int unsigned TAG_W    = TAP_W + COL_W + ROW_W + 2;
    localparam int unsigned LAST_ROW = (KROWS - 1) + ((IMG_H - KROWS) / ROW_STEP) * ROW_STEP;

    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] BASE_FIRST = ADDR_W'((KROWS - 1) * IMG_W);
    // From the last column of row r to column 0 of row r+ROW_STEP.
    localparam logic [ADDR_W-1:0] ROW_JUMP   = ADDR_W'((ROW_STEP - 1) * IMG_W + 1);
    localparam logic [TAP_W-1:0]  TAP_LAST   = TAP_W'(KROWS - 1);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_FIRST  = ROW_W'(KROWS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(LAST_ROW);
    localparam logic [ROW_W-1:0]  ROW_INC    = ROW_W'(ROW_STEP);
    localparam logic [DRN_W-1:0]  DRN_LAST   = DRN_W'(RAM_LAT);

    sched_state_t      state_q,   state_d;
    logic [ROW_W-1:0]  row_q,     row_d;
    logic [COL_W-1:0]  col_q,     col_d;
    logic [TAP_W-1:0]  tap_q,     tap_d;
    logic [ADDR_W-1:0] base_q,    base_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DRN_W-1:0]  drn_q,     drn_d;
    logic              rd_en_q,   rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [TAG_W-1:0]  tag_q,     tag_d;
    logic              done_q,    done_d;

    logic              tap_last, col_last, row_last, eol, eof;
    logic              tag_valid;
    logic [TAG_W-1:0]  tag_data;

    assign tap_last = (tap_q == TAP_LAST);
    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);
    assign eol      = tap_last & col_last;
    assign eof      = eol & row_last;

    // State, counters and the registered read/tag issue stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            row_q     <= ROW_FIRST;
            col_q     <= '0;
            tap_q     <= '0;
            base_q    <= '0;
            addr_q    <= '0;
            drn_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            tag_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            tap_q     <= tap_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            drn_q     <= drn_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            tag_q     <= tag_d;
            done_q    <= done_d;
        end
    end

    // Next state: walk taps bottom-up using a running subtract, then columns, then rows.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        tap_d     = tap_q;
        base_d    = base_q;
        addr_d    = addr_q;
        drn_d     = drn_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        tag_d     = tag_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = FETCH;
                    row_d   = ROW_FIRST;
                    col_d   = '0;
                    tap_d   = '0;
                    base_d  = BASE_FIRST;
                    addr_d  = BASE_FIRST;
                end
            end
            FETCH: begin
                if (!bus.stall) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = addr_q;
                    tag_d     = {tap_q, col_q, row_q, eol, eof};
                    if (!tap_last) begin
                        tap_d  = tap_q + 1'b1;
                        addr_d = addr_q - ROW_STRIDE;
                    end else begin
                        tap_d = '0;
                        if (!col_last) begin
                            col_d  = col_q + 1'b1;
                            base_d = base_q + 1'b1;
                            addr_d = base_q + 1'b1;
                        end else if (!row_last) begin
                            col_d  = '0;
                            row_d  = row_q + ROW_INC;
                            base_d = base_q + ROW_JUMP;
                            addr_d = base_q + ROW_JUMP;
                        end else begin
                            state_d = DRAIN;
                            drn_d   = '0;
                        end
                    end
                end
            end
            DRAIN: begin
                // Lasts until the final tag has left the delay line.
                if (drn_q == DRN_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    drn_d = drn_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.abort) begin
            state_d = IDLE;
            rd_en_d = 1'b0;
            done_d  = 1'b0;
        end
    end

    tag_delay_line #(
        .WIDTH (TAG_W),
        .DEPTH (RAM_LAT)
    ) u_tags (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (bus.abort),
        .valid_i (rd_en_q),
        .data_i  (tag_q),
        .valid_o (tag_valid),
        .data_o  (tag_data)
    );

    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.tag_valid = tag_valid;
    assign {bus.tag_tap, bus.tag_col, bus.tag_row, bus.tag_eol, bus.tag_eof} = tag_data;

endmodule

// File: tb/tb_window_addr_scheduler.sv
// Bench for window_addr_scheduler: three configurations checked every cycle
// against an index-arithmetic reference of the read stream.
module tb_window_addr_scheduler;
    import window_addr_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic st [3];
    logic sl [3];
    logic ab [3];

    window_addr_scheduler_if #(.ADDR_W(20), .TAP_W(sched_clog2(4)), .COL_W(sched_clog2(256)), .ROW_W(sched_clog2(256))) if0 ();
    window_addr_scheduler_if #(.ADDR_W(8),  .TAP_W(sched_clog2(4)), .COL_W(sched_clog2(8)),   .ROW_W(sched_clog2(16)))  if1 ();
    window_addr_scheduler_if #(.ADDR_W(5),  .TAP_W(sched_clog2(3)), .COL_W(sched_clog2(4)),   .ROW_W(sched_clog2(7)))   if2 ();

    assign if0.start = st[0]; assign if0.stall = sl[0]; assign if0.abort = ab[0];
    assign if1.start = st[1]; assign if1.stall = sl[1]; assign if1.abort = ab[1];
    assign if2.start = st[2]; assign if2.stall = sl[2]; assign if2.abort = ab[2];

    window_addr_scheduler #(.ADDR_W(20), .IMG_W(256), .IMG_H(256), .KROWS(4), .ROW_STEP(1), .RAM_LAT(1))
        u0 (.clk(clk), .reset(rst), .bus(if0));
    window_addr_scheduler #(.ADDR_W(8), .IMG_W(8), .IMG_H(16), .KROWS(4), .ROW_STEP(2), .RAM_LAT(2))
        u1 (.clk(clk), .reset(rst), .bus(if1));
    window_addr_scheduler #(.ADDR_W(5), .IMG_W(4), .IMG_H(7), .KROWS(3), .ROW_STEP(3), .RAM_LAT(0))
        u2 (.clk(clk), .reset(rst), .bus(if2));

    int checks = 0;
    int errors = 0;

    // Reference configuration per instance.
    int pw [3];
    int ph [3];
    int pk [3];
    int ps [3];
    int pl [3];
    int total [3];

    // Reference state: frame active, reads issued, recent issue indices.
    bit act [3];
    int n [3];
    bit lastprev [3];
    int hist [3][4];
    bit e_en [3];
    int e_idx [3];
    int e_tag [3];
    bit e_done [3];
    int rdcnt [3];

    logic [31:0] o_en, o_addr, o_busy, o_done, o_tv, o_tap, o_col, o_row, o_eol, o_eof;

    logic [31:0] seq1 [8] = '{768, 512, 256, 0, 769, 513, 257, 1};
    logic [31:0] capt [8];
    int ncap;
    int sen;
    bit stalled;

    task automatic chk(input int k, input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL u%0d.%s observed=%0d expected=%0d", k, nm, obs, exp);
        end
    endtask

    // Read number idx of a frame, straight from the window geometry.
    function automatic void exp_read(input int k, input int idx, output int a, output int tp,
                                     output int cl, output int rw, output bit el, output bit ef);
        tp = idx % pk[k];
        cl = (idx / pk[k]) % pw[k];
        rw = pk[k] - 1 + (idx / (pk[k] * pw[k])) * ps[k];
        a  = (rw - tp) * pw[k] + cl;
        el = (tp == pk[k] - 1) && (cl == pw[k] - 1);
        ef = (idx == total[k] - 1);
    endfunction

    task automatic sample(input int k);
        case (k)
            0: begin
                o_en = 32'(if0.rd_en); o_addr = 32'(if0.rd_addr); o_busy = 32'(if0.busy); o_done = 32'(if0.done);
                o_tv = 32'(if0.tag_valid); o_tap = 32'(if0.tag_tap); o_col = 32'(if0.tag_col);
                o_row = 32'(if0.tag_row); o_eol = 32'(if0.tag_eol); o_eof = 32'(if0.tag_eof);
            end
            1: begin
                o_en = 32'(if1.rd_en); o_addr = 32'(if1.rd_addr); o_busy = 32'(if1.busy); o_done = 32'(if1.done);
                o_tv = 32'(if1.tag_valid); o_tap = 32'(if1.tag_tap); o_col = 32'(if1.tag_col);
                o_row = 32'(if1.tag_row); o_eol = 32'(if1.tag_eol); o_eof = 32'(if1.tag_eof);
            end
            default: begin
                o_en = 32'(if2.rd_en); o_addr = 32'(if2.rd_addr); o_busy = 32'(if2.busy); o_done = 32'(if2.done);
                o_tv = 32'(if2.tag_valid); o_tap = 32'(if2.tag_tap); o_col = 32'(if2.tag_col);
                o_row = 32'(if2.tag_row); o_eol = 32'(if2.tag_eol); o_eof = 32'(if2.tag_eof);
            end
        endcase
    endtask

    task automatic model_reset(input int k);
        act[k] = 1'b0; n[k] = 0; lastprev[k] = 1'b0;
        e_en[k] = 1'b0; e_idx[k] = -1; e_tag[k] = -1; e_done[k] = 1'b0;
        for (int i = 0; i < 4; i++) hist[k][i] = -1;
    endtask

    // Advance the reference by one clock edge using the inputs seen at that edge.
    task automatic model_step(input int k);
        int ti;
        e_en[k] = 1'b0;
        e_idx[k] = -1;
        if (ab[k]) begin
            model_reset(k);
        end else begin
            e_done[k] = lastprev[k];
            if (act[k] && !sl[k] && n[k] < total[k]) begin
                e_en[k] = 1'b1;
                e_idx[k] = n[k];
                n[k]++;
            end
            if (e_done[k]) act[k] = 1'b0;
            else if (!act[k] && st[k]) begin
                act[k] = 1'b1;
                n[k] = 0;
            end
            ti = (pl[k] == 0) ? e_idx[k] : hist[k][pl[k]-1];
            for (int i = pl[k] - 1; i > 0; i--) hist[k][i] = hist[k][i-1];
            if (pl[k] > 0) hist[k][0] = e_idx[k];
            e_tag[k] = ti;
            lastprev[k] = (ti == total[k] - 1);
        end
    endtask

    task automatic check_outputs(input int k);
        int a, tp, cl, rw;
        bit el, ef;
        sample(k);
        rdcnt[k] += int'(o_en);
        chk(k, "rd_en", o_en, 32'(e_en[k]));
        if (e_en[k]) begin
            exp_read(k, e_idx[k], a, tp, cl, rw, el, ef);
            chk(k, "rd_addr", o_addr, 32'(a));
        end
        chk(k, "tag_valid", o_tv, 32'(e_tag[k] >= 0));
        if (e_tag[k] >= 0) begin
            exp_read(k, e_tag[k], a, tp, cl, rw, el, ef);
            chk(k, "tag_tap", o_tap, 32'(tp));
            chk(k, "tag_col", o_col, 32'(cl));
            chk(k, "tag_row", o_row, 32'(rw));
            chk(k, "tag_eol", o_eol, 32'(el));
            chk(k, "tag_eof", o_eof, 32'(ef));
        end
        chk(k, "busy", o_busy, 32'(act[k]));
        chk(k, "done", o_done, 32'(e_done[k]));
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        for (int k = 0; k < 3; k++) check_outputs(k);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0; sl[k] = 1'b0; ab[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < 3; k++) model_reset(k);
        for (int k = 0; k < 3; k++) check_outputs(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_outputs(k);
        rst = 1'b0;
    endtask

    initial begin
        pw = '{256, 8, 4};
        ph = '{256, 16, 7};
        pk = '{4, 4, 3};
        ps = '{1, 2, 3};
        pl = '{1, 2, 0};
        for (int k = 0; k < 3; k++) begin
            total[k] = ((ph[k] - pk[k]) / ps[k] + 1) * pw[k] * pk[k];
            st[k] = 1'b0; sl[k] = 1'b0; ab[k] = 1'b0;
            rdcnt[k] = 0;
        end
        for (int i = 0; i < 8; i++) capt[i] = '1;

        #2;
        do_reset();
        repeat (3) tick();

        // First column pair, with a 5-cycle stall right after address 512.
        st[0] = 1'b1; tick(); st[0] = 1'b0;
        ncap = 0; sen = 0; stalled = 1'b0;
        for (int i = 0; i < 60 && ncap < 8; i++) begin
            if (n[0] == 2 && !stalled) begin
                sl[0] = 1'b1;
                repeat (5) begin
                    tick(); sample(0); sen += int'(o_en);
                end
                sl[0] = 1'b0;
                stalled = 1'b1;
            end
            tick(); sample(0);
            if (o_en[0]) begin
                capt[ncap] = o_addr;
                ncap++;
            end
        end
        for (int i = 0; i < 8; i++) chk(0, $sformatf("first_seq[%0d]", i), capt[i], seq1[i]);
        chk(0, "rd_en_while_stalled", 32'(sen), 32'd0);

        // Through the end of row 3 into row 4 with random stalls and stray starts.
        for (int i = 0; i < 3000 && n[0] < 1040; i++) begin
            sl[0] = ($urandom_range(0, 7) == 0);
            st[0] = ($urandom_range(0, 31) == 0);
            tick();
        end
        sl[0] = 1'b0; st[0] = 1'b0;

        // Abort with a simultaneous start: abort wins, nothing restarts.
        ab[0] = 1'b1; st[0] = 1'b1; tick(); ab[0] = 1'b0; st[0] = 1'b0;
        repeat (4) tick();

        // Fresh start, abort at read 10, then restart from the top.
        st[0] = 1'b1; tick(); st[0] = 1'b0;
        for (int i = 0; i < 40 && n[0] < 10; i++) tick();
        ab[0] = 1'b1; tick(); ab[0] = 1'b0;
        repeat (5) tick();
        st[0] = 1'b1; tick(); st[0] = 1'b0;
        tick(); sample(0);
        chk(0, "restart_after_abort", o_addr, 32'd768);

        // Reset at read 10, then restart from the top.
        for (int i = 0; i < 40 && n[0] < 10; i++) tick();
        do_reset();
        repeat (5) tick();
        st[0] = 1'b1; tick(); st[0] = 1'b0;
        tick(); sample(0);
        chk(0, "restart_after_reset", o_addr, 32'd768);
        repeat (6) tick();
        ab[0] = 1'b1; tick(); ab[0] = 1'b0;

        // Small frames run to completion: start together with stall, random stalls.
        rdcnt[1] = 0; rdcnt[2] = 0;
        st[1] = 1'b1; sl[1] = 1'b1; st[2] = 1'b1; sl[2] = 1'b1;
        tick();
        st[1] = 1'b0; st[2] = 1'b0;
        for (int i = 0; i < 2000 && (act[1] || act[2]); i++) begin
            sl[1] = ($urandom_range(0, 3) == 0);
            sl[2] = ($urandom_range(0, 3) == 0);
            st[1] = act[1] && ($urandom_range(0, 15) == 0);
            st[2] = act[2] && ($urandom_range(0, 15) == 0);
            tick();
        end
        sl[1] = 1'b0; sl[2] = 1'b0; st[1] = 1'b0; st[2] = 1'b0;
        repeat (3) tick();
        chk(1, "frame_reads_stalled", 32'(rdcnt[1]), 32'd224);
        chk(2, "frame_reads_stalled", 32'(rdcnt[2]), 32'd24);

        // Same frames back to back without stalls.
        rdcnt[1] = 0; rdcnt[2] = 0;
        st[1] = 1'b1; st[2] = 1'b1; tick(); st[1] = 1'b0; st[2] = 1'b0;
        for (int i = 0; i < 1000 && (act[1] || act[2]); i++) tick();
        repeat (3) tick();
        chk(1, "frame_reads_clean", 32'(rdcnt[1]), 32'd224);
        chk(2, "frame_reads_clean", 32'(rdcnt[2]), 32'd24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
